// File: rtl/game_flow_if.sv
// Bundles the pulse inputs, character position and registered status outputs of
// game_flow_ctrl. The sequencer takes the slave side and the stimulus side takes the master side.
interface game_flow_if #(
    parameter int unsigned PHY_WIDTH        = 16,
    parameter int unsigned SIGNED_PHY_WIDTH = PHY_WIDTH + 1
);
    logic                        start_pulse;
    logic                        pause_pulse;
    logic                        char_tick_in;
    logic                        sec_tick_in;
    logic [SIGNED_PHY_WIDTH-1:0] char_pos_y;
    logic [1:0]                  game_state;
    logic                        char_tick_out;
    logic                        char_init;
    logic [PHY_WIDTH-1:0]        game_time;
    logic [PHY_WIDTH-1:0]        best_y;
    logic                        win;

    modport master (
        output start_pulse, pause_pulse, char_tick_in, sec_tick_in, char_pos_y,
        input  game_state, char_tick_out, char_init, game_time, best_y, win
    );

    modport slave (
        input  start_pulse, pause_pulse, char_tick_in, sec_tick_in, char_pos_y,
        output game_state, char_tick_out, char_init, game_time, best_y, win
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencer: IDLE/PLAY/PAUSE/WIN state machine, gated physics tick, saturating run
// timer and best-height record. All outputs are registered.
module game_flow_ctrl #(
    parameter int unsigned PHY_WIDTH        = 16,
    parameter int unsigned SIGNED_PHY_WIDTH = PHY_WIDTH + 1,
    parameter int          GOAL_Y           = 3000
) (
    input  logic         sys_clk,
    input  logic         sys_rst,
    game_flow_if.slave   bus
);
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StPause = 2'd2,
        StWin   = 2'd3
    } state_e;

    localparam logic signed [SIGNED_PHY_WIDTH-1:0] GoalY = SIGNED_PHY_WIDTH'(GOAL_Y);

    state_e                      state_q, state_d;
    logic [PHY_WIDTH-1:0]        game_time_q, game_time_d;
    logic [PHY_WIDTH-1:0]        best_y_q, best_y_d;
    logic                        char_tick_q, char_init_q, char_init_d, win_q;
    logic                        goal_hit, pos_neg;
    logic [SIGNED_PHY_WIDTH-1:0] best_ext;

    assign goal_hit = $signed(bus.char_pos_y) >= GoalY;
    assign pos_neg  = bus.char_pos_y[SIGNED_PHY_WIDTH-1];
    assign best_ext = SIGNED_PHY_WIDTH'(best_y_q);

    always_comb begin
        state_d     = state_q;
        game_time_d = game_time_q;
        best_y_d    = best_y_q;
        char_init_d = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start_pulse) begin
                    state_d     = StPlay;
                    game_time_d = '0;
                    best_y_d    = '0;
                    char_init_d = 1'b1;
                end
            end
            StPlay: begin
                // Goal crossing beats a coincident pause.
                if (goal_hit) begin
                    state_d = StWin;
                end else if (bus.pause_pulse) begin
                    state_d = StPause;
                end
                if (bus.sec_tick_in && (game_time_q != '1)) begin
                    game_time_d = game_time_q + 1'b1;
                end
                if (!pos_neg && (bus.char_pos_y > best_ext)) begin
                    best_y_d = bus.char_pos_y[PHY_WIDTH-1:0];
                end
            end
            StPause: begin
                if (bus.pause_pulse) begin
                    state_d = StPlay;
                end
            end
            StWin: begin
                if (bus.start_pulse) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= StIdle;
            game_time_q <= '0;
            best_y_q    <= '0;
            char_tick_q <= 1'b0;
            char_init_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            game_time_q <= game_time_d;
            best_y_q    <= best_y_d;
            // Gate on the state before this edge so a resume-edge tick is dropped.
            char_tick_q <= bus.char_tick_in && (state_q == StPlay);
            char_init_q <= char_init_d;
            win_q       <= (state_d == StWin);
        end
    end

    assign bus.game_state    = state_q;
    assign bus.char_tick_out = char_tick_q;
    assign bus.char_init     = char_init_q;
    assign bus.game_time     = game_time_q;
    assign bus.best_y        = best_y_q;
    assign bus.win           = win_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed bench for game_flow_ctrl: start, saturation, pause gating, best height,
// win priority, restart and mid-run reset.
module tb_game_flow_ctrl;
    localparam int PW = 16;
    localparam int SW = 17;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 sys_clk = ~sys_clk;

    game_flow_if #(.PHY_WIDTH(PW), .SIGNED_PHY_WIDTH(SW)) bus ();

    game_flow_ctrl #(.PHY_WIDTH(PW), .SIGNED_PHY_WIDTH(SW), .GOAL_Y(3000)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    task automatic step();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic test_reset();
        bus.start_pulse  = 1'b0;
        bus.pause_pulse  = 1'b0;
        bus.char_tick_in = 1'b0;
        bus.sec_tick_in  = 1'b0;
        bus.char_pos_y   = '0;
        sys_rst = 1'b1;
        step();
        step();
        sys_rst = 1'b0;
        n_checks++;
        if ({bus.game_state, bus.char_tick_out, bus.char_init, bus.win} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got state=%0d tick=%0b init=%0b win=%0b required all 0",
                     bus.game_state, bus.char_tick_out, bus.char_init, bus.win);
        end
        n_checks++;
        if (bus.game_time !== 16'd0 || bus.best_y !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got time=%0d best=%0d required 0 0",
                     bus.game_time, bus.best_y);
        end
        // Pause in IDLE must be ignored.
        bus.pause_pulse = 1'b1;
        step();
        bus.pause_pulse = 1'b0;
        step();
        n_checks++;
        if (bus.game_state !== 2'd0) begin
            n_fail++;
            $display("FAIL idle_pause: got state=%0d required 0", bus.game_state);
        end
        step();
        bus.start_pulse  = 1'b1;
        bus.char_tick_in = 1'b1;
        step();
        bus.start_pulse  = 1'b0;
        bus.char_tick_in = 1'b0;
        n_checks++;
        if (bus.game_state !== 2'd1 || bus.char_init !== 1'b1 || bus.char_tick_out !== 1'b0) begin
            n_fail++;
            $display("FAIL start_edge: got state=%0d init=%0b tick=%0b required 1 1 0",
                     bus.game_state, bus.char_init, bus.char_tick_out);
        end
        n_checks++;
        if (bus.game_time !== 16'd0 || bus.best_y !== 16'd0) begin
            n_fail++;
            $display("FAIL start_regs: got time=%0d best=%0d required 0 0",
                     bus.game_time, bus.best_y);
        end
        step();
        n_checks++;
        if (bus.char_init !== 1'b0 || bus.game_state !== 2'd1) begin
            n_fail++;
            $display("FAIL init_one_cycle: got init=%0b state=%0d required 0 1",
                     bus.char_init, bus.game_state);
        end
    endtask

    task automatic test_saturation();
        bus.sec_tick_in = 1'b1;
        repeat (100) step();
        n_checks++;
        if (bus.game_time !== 16'd100) begin
            n_fail++;
            $display("FAIL time_count: got %0d required 100", bus.game_time);
        end
        repeat (69900) step();
        n_checks++;
        if (bus.game_time !== 16'd65535) begin
            n_fail++;
            $display("FAIL time_saturate: got %0d required 65535", bus.game_time);
        end
        bus.pause_pulse = 1'b1;
        step();
        bus.pause_pulse = 1'b0;
        repeat (10) step();
        n_checks++;
        if (bus.game_state !== 2'd2 || bus.game_time !== 16'd65535) begin
            n_fail++;
            $display("FAIL pause_freeze: got state=%0d time=%0d required 2 65535",
                     bus.game_state, bus.game_time);
        end
        bus.pause_pulse = 1'b1;
        step();
        bus.pause_pulse = 1'b0;
        bus.sec_tick_in = 1'b0;
        n_checks++;
        if (bus.game_state !== 2'd1) begin
            n_fail++;
            $display("FAIL resume: got state=%0d required 1", bus.game_state);
        end
    endtask

    task automatic test_pause_ticks();
        int at_pause = 0;
        int in_pause = 0;
        int after    = 0;
        logic [1:0] st_pause = 2'd0;
        logic [1:0] st_resume = 2'd0;
        for (int c = 0; c < 100; c++) begin
            bus.char_tick_in = (c % 10 == 0);
            bus.pause_pulse  = (c == 20) || (c == 70);
            step();
            if (c == 20) begin
                at_pause = int'(bus.char_tick_out);
                st_pause = bus.game_state;
            end else if (c > 20 && c <= 70) begin
                in_pause += int'(bus.char_tick_out);
            end else if (c > 70) begin
                after += int'(bus.char_tick_out);
            end
            if (c == 70) st_resume = bus.game_state;
        end
        bus.char_tick_in = 1'b0;
        bus.pause_pulse  = 1'b0;
        n_checks++;
        if (at_pause !== 1 || st_pause !== 2'd2) begin
            n_fail++;
            $display("FAIL tick_on_pause: got tick=%0d state=%0d required 1 2", at_pause, st_pause);
        end
        n_checks++;
        if (in_pause !== 0) begin
            n_fail++;
            $display("FAIL ticks_in_pause: got %0d required 0", in_pause);
        end
        n_checks++;
        if (after !== 2 || st_resume !== 2'd1) begin
            n_fail++;
            $display("FAIL ticks_after_resume: got ticks=%0d state=%0d required 2 1",
                     after, st_resume);
        end
    endtask

    task automatic test_best_y_win();
        int          pos [5]  = '{-20, 100, 80, 2999, 3000};
        logic [15:0] best [5] = '{16'd0, 16'd100, 16'd100, 16'd2999, 16'd3000};
        for (int i = 0; i < 5; i++) begin
            bus.char_pos_y   = SW'(pos[i]);
            bus.pause_pulse  = (i == 4);
            bus.char_tick_in = (i == 4);
            step();
            n_checks++;
            if (bus.best_y !== best[i]) begin
                n_fail++;
                $display("FAIL best_y_%0d: got %0d required %0d", i, bus.best_y, best[i]);
            end
        end
        bus.pause_pulse = 1'b0;
        n_checks++;
        if (bus.game_state !== 2'd3 || bus.win !== 1'b1 || bus.char_tick_out !== 1'b1) begin
            n_fail++;
            $display("FAIL win_detect: got state=%0d win=%0b tick=%0b required 3 1 1",
                     bus.game_state, bus.win, bus.char_tick_out);
        end
        bus.pause_pulse = 1'b1;
        step();
        bus.pause_pulse  = 1'b0;
        bus.char_tick_in = 1'b0;
        n_checks++;
        if (bus.game_state !== 2'd3 || bus.win !== 1'b1 || bus.char_tick_out !== 1'b0) begin
            n_fail++;
            $display("FAIL win_hold: got state=%0d win=%0b tick=%0b required 3 1 0",
                     bus.game_state, bus.win, bus.char_tick_out);
        end
        bus.char_pos_y = '0;
    endtask

    task automatic test_restart();
        bus.start_pulse = 1'b1;
        step();
        bus.start_pulse = 1'b0;
        n_checks++;
        if (bus.game_state !== 2'd0 || bus.win !== 1'b0 || bus.game_time !== 16'd65535
            || bus.best_y !== 16'd3000) begin
            n_fail++;
            $display("FAIL win_to_idle: got state=%0d win=%0b time=%0d best=%0d required 0 0 65535 3000",
                     bus.game_state, bus.win, bus.game_time, bus.best_y);
        end
        step();
        bus.start_pulse = 1'b1;
        bus.sec_tick_in = 1'b1;
        step();
        bus.start_pulse = 1'b0;
        n_checks++;
        if (bus.game_state !== 2'd1 || bus.char_init !== 1'b1 || bus.game_time !== 16'd0
            || bus.best_y !== 16'd0) begin
            n_fail++;
            $display("FAIL restart: got state=%0d init=%0b time=%0d best=%0d required 1 1 0 0",
                     bus.game_state, bus.char_init, bus.game_time, bus.best_y);
        end
        repeat (3) step();
        bus.sec_tick_in = 1'b0;
        n_checks++;
        if (bus.game_time !== 16'd3 || bus.char_init !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_count: got time=%0d init=%0b required 3 0",
                     bus.game_time, bus.char_init);
        end
    endtask

    task automatic test_reset_midrun();
        bus.char_pos_y  = SW'(500);
        step();
        bus.pause_pulse = 1'b1;
        step();
        bus.pause_pulse = 1'b0;
        bus.sec_tick_in = 1'b1;
        repeat (4) step();
        n_checks++;
        if (bus.game_state !== 2'd2 || bus.game_time !== 16'd3 || bus.best_y !== 16'd500) begin
            n_fail++;
            $display("FAIL pause_hold: got state=%0d time=%0d best=%0d required 2 3 500",
                     bus.game_state, bus.game_time, bus.best_y);
        end
        sys_rst = 1'b1;
        bus.start_pulse  = 1'b1;
        bus.pause_pulse  = 1'b1;
        bus.char_tick_in = 1'b1;
        step();
        n_checks++;
        if (bus.game_state !== 2'd0 || bus.game_time !== 16'd0 || bus.best_y !== 16'd0
            || bus.char_tick_out !== 1'b0 || bus.char_init !== 1'b0 || bus.win !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: got state=%0d time=%0d best=%0d tick=%0b init=%0b win=%0b required all 0",
                     bus.game_state, bus.game_time, bus.best_y, bus.char_tick_out,
                     bus.char_init, bus.win);
        end
        sys_rst = 1'b0;
        bus.start_pulse  = 1'b0;
        bus.pause_pulse  = 1'b0;
        bus.char_tick_in = 1'b0;
        bus.sec_tick_in  = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_saturation();
        test_pause_ticks();
        test_best_y_win();
        test_restart();
        test_reset_midrun();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/game_flow_ctrl.md
# game_flow_ctrl

Top-level game sequencer. It sits between the tick dividers, the button edge detectors and the `character` block. It gates the character physics tick, owns the game timer and the best-height record, and decides when a run starts, pauses and is won. Its registered outputs replace the free-running `game_time` counter and directly clock-enable character updates.

## Interface
Parameters:
- PHY_WIDTH, 16: unsigned physics/timer width.
- SIGNED_PHY_WIDTH, PHY_WIDTH+1: width of the signed character position input.
- GOAL_Y, 3000: absolute height at or above which the run is won; signed compare.

Ports:
- sys_clk  in  1  system clock, 100 MHz.
- sys_rst  in  1  reset, synchronous, active-high.
- start_pulse  in  1  one-cycle pulse from the jump button edge detector.
- pause_pulse  in  1  one-cycle pulse from the pause button edge detector.
- char_tick_in  in  1  one-cycle character physics tick from fq_div.
- sec_tick_in  in  1  one-cycle game-time tick from fq_div.
- char_pos_y  in  SIGNED_PHY_WIDTH  character absolute y, two's complement.
- game_state  out  2  0=IDLE, 1=PLAY, 2=PAUSE, 3=WIN.
- char_tick_out  out  1  gated physics tick for `character`.
- char_init  out  1  one-cycle request to reinitialise the character and block generator.
- game_time  out  PHY_WIDTH  elapsed ticks in the current run.
- best_y  out  PHY_WIDTH  highest non-negative char_pos_y in the current run.
- win  out  1  high while game_state==WIN.

## Operation
- All outputs are registered.
- Reset values: game_state=IDLE; char_tick_out=0, char_init=0, game_time=0, best_y=0, win=0.
- IDLE:
  - start_pulse -> PLAY. In the same edge, game_time and best_y are cleared and char_init is set for exactly one cycle.
  - pause_pulse is ignored.
- PLAY:
  - If signed char_pos_y >= GOAL_Y -> WIN. Else if pause_pulse -> PAUSE. Win has priority over pause.
  - start_pulse is ignored.
- PAUSE:
  - pause_pulse -> PLAY. start_pulse is ignored.
  - Timer, best_y and ticks are frozen.
  - The goal is not evaluated.
- WIN:
  - start_pulse -> IDLE. pause_pulse is ignored.
  - game_time and best_y hold their final values until the next IDLE->PLAY.
- game_time:
  - Increments by 1 on sec_tick_in when the current registered state is PLAY.
  - Still counts on the edge that leaves PLAY.
  - Saturates at 2^PHY_WIDTH-1; no wrap.
- best_y:
  - In PLAY, if char_pos_y is non-negative and greater than best_y, then best_y <= char_pos_y[PHY_WIDTH-1:0].
  - Negative positions are never stored.
- char_tick_out <= char_tick_in & (current state==PLAY).
- win <= (next state==WIN).
- game_state is the encoded state register, with no output decode delay.

## Timing
- Tick latency: one cycle from char_tick_in to char_tick_out.
- char_init and game_state=PLAY become visible on the same cycle, one cycle after start_pulse.
- char_tick_out is 0 on the char_init cycle, because the tick was sampled while the state was still IDLE.
- Pause/resume: the state changes one cycle after the pulse. A char_tick_in coincident with pause_pulse in PLAY still propagates. A char_tick_in coincident with the resume pulse does not.
- Win detect: one cycle latency. A char_tick_in on the win-detect edge is still forwarded, so at most one tick is issued after the goal crossing.
- sys_rst asserted mid-run forces all reset values at the next edge. It overrides every pulse input.
- Inputs are assumed to be one-cycle pulses. A held level behaves like repeated pulses, so a held pause toggles PLAY/PAUSE every cycle. Upstream edge detection is therefore mandatory.

## Test plan
- Reset, then start_pulse at cycle 5 -> game_state=1 and char_init=1 at cycle 6 only; game_time=0, best_y=0.
- In PLAY, send 70000 sec_tick_in -> game_time stops at 65535 with no wrap. A pause_pulse then freezes it while sec_tick_in continues.
- char_tick_in every 10 cycles, pause_pulse at a tick edge, resume 50 cycles later -> exactly one tick forwarded after the pause edge; none while in PAUSE; ticks resume after the state returns to PLAY.
- Drive char_pos_y through -20, 100, 80, 2999, 3000 -> best_y 0, 100, 100, 2999, 3000. game_state=3 and win=1 the cycle after 3000. A pause_pulse on the same cycle as 3000 is ignored, since win has priority.
- In WIN, start_pulse -> IDLE with game_time held. A second start_pulse -> PLAY with game_time=0, best_y=0 and a char_init pulse.
- sys_rst asserted in PAUSE with start_pulse and pause_pulse both high -> IDLE, all outputs 0 the next cycle.
